// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: ROM port, redirect request, decode handshake and status.
// The master side is the fetch unit; the slave side is the ROM/decode/branch environment.
interface instruction_fetch_if #(
   parameter int ROM_AW = 6
);
   logic [ROM_AW-1:0] rom_address;
   logic [31:0]       rom_instruction;
   logic              redirect;
   logic [31:0]       redirect_target;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instruction;
   logic [31:0]       out_pc;
   logic [31:0]       out_pc_plus4;
   logic [15:0]       fetch_count;
   logic              fetch_fault;

   modport master (
      output rom_address,
      input  rom_instruction,
      input  redirect,
      input  redirect_target,
      output out_valid,
      input  out_ready,
      output out_instruction,
      output out_pc,
      output out_pc_plus4,
      output fetch_count,
      output fetch_fault
   );

   modport slave (
      input  rom_address,
      output rom_instruction,
      output redirect,
      output redirect_target,
      input  out_valid,
      output out_ready,
      input  out_instruction,
      input  out_pc,
      input  out_pc_plus4,
      input  fetch_count,
      input  fetch_fault
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: registered pc feeding a synchronous ROM, one instruction per cycle, one bubble per redirect.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects in FAULT; otherwise target bits [1:0] are dropped.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ROM_AW   = 6
) (
   input  logic                clock,
   input  logic                reset,
   instruction_fetch_if.master bus
);
   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [15:0] count_q, count_d;
   logic        fault_q, fault_d;
   logic [31:0] target;
   logic        misalign;
   logic        valid;
   logic        accept;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target   = bus.redirect_target;
   assign misalign = bus.redirect && (bus.redirect_target[1:0] != 2'b00);
`else
   logic unused_target_lsbs;
   assign unused_target_lsbs = ^bus.redirect_target[1:0];
   assign target   = {bus.redirect_target[31:2], 2'b00};
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      valid   = 1'b0;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     valid   = !bus.redirect;
         FAULT:   state_d = FAULT;
         default: state_d = BOOT;
      endcase
      // Any redirect re-targets the stream; only an aligned one leaves FAULT.
      if (bus.redirect) begin
         state_d = misalign ? FAULT : RUN;
         fault_d = misalign;
      end
   end

   assign accept  = valid && bus.out_ready;
   assign pc_d    = bus.redirect ? target : (accept ? pc_q + 32'd4 : pc_q);
   assign count_d = count_q + {15'd0, accept};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         count_q <= 16'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         fault_q <= fault_d;
      end
   end

   // The ROM registers this address, so its data lines up with pc_q next cycle.
   assign bus.rom_address     = reset ? RESET_PC[ROM_AW+1:2] : pc_d[ROM_AW+1:2];
   assign bus.out_valid       = valid;
   assign bus.out_instruction = bus.rom_instruction;
   assign bus.out_pc          = pc_q;
   assign bus.out_pc_plus4    = pc_q + 32'd4;
   assign bus.fetch_count     = count_q;
   assign bus.fetch_fault     = fault_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a synchronous ROM model plus a queue of expected accepted pcs.
// Honours FETCH_MISALIGN_TRAP_EN the same way the design does.
module tb_instruction_fetch;
   localparam int AW = 6;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   instruction_fetch_if #(.ROM_AW(AW)) bus ();

   instruction_fetch #(
      .RESET_PC (32'h0000_0000),
      .ROM_AW   (AW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] rom_mem [0:(1<<AW)-1];
   always @(posedge clock) bus.rom_instruction <= rom_mem[bus.rom_address];

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q [$];

   function automatic logic [31:0] rom_word(input logic [31:0] pc);
      logic [AW-1:0] idx;
      idx = pc[AW+1:2];
      return rom_mem[idx];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One cycle: drive at the falling edge, sample just after, score any transfer.
   task automatic cyc(input logic rdy, input logic rd, input logic [31:0] tgt);
      logic [31:0] epc;
      @(negedge clock);
      bus.out_ready       = rdy;
      bus.redirect        = rd;
      bus.redirect_target = tgt;
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", exp_q.size(), 1);
         end else begin
            epc = exp_q.pop_front();
            check_eq("acc_pc", bus.out_pc, epc);
            check_eq("acc_inst", bus.out_instruction, rom_word(epc));
            check_eq("acc_pc4", bus.out_pc_plus4, epc + 32'd4);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 32'h5A00_0000 + i * 32'h0001_0003;
      bus.rom_instruction = 32'd0;
      bus.out_ready       = 1'b0;
      bus.redirect        = 1'b0;
      bus.redirect_target = 32'd0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check_eq("rst_valid", bus.out_valid, 0);
      check_eq("rst_count", bus.fetch_count, 0);
      check_eq("rst_fault", bus.fetch_fault, 0);
      check_eq("rst_romaddr", bus.rom_address, 0);
      check_eq("rst_pc", bus.out_pc, 0);

      @(negedge clock);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check_eq("boot_valid", bus.out_valid, 0);

      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0);
         check_eq("stall_valid", bus.out_valid, 1);
         check_eq("stall_pc", bus.out_pc, 32'h8);
         check_eq("stall_inst", bus.out_instruction, rom_word(32'h8));
         check_eq("stall_romaddr", bus.rom_address, 2);
         check_eq("stall_count", bus.fetch_count, 2);
      end
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      cyc(1, 0, 0);
      cyc(1, 0, 0);

      cyc(1, 1, 32'h40);
      check_eq("redir_pc", bus.out_pc, 32'h10);
      check_eq("redir_valid", bus.out_valid, 0);
      check_eq("redir_romaddr", bus.rom_address, 16);
      check_eq("redir_count", bus.fetch_count, 4);
      exp_q.push_back(32'h40);
      cyc(1, 0, 0);

      cyc(1, 1, 32'hF8);
      check_eq("redir_count2", bus.fetch_count, 5);
      exp_q.push_back(32'hF8);
      cyc(1, 0, 0);
      exp_q.push_back(32'hFC);
      cyc(1, 0, 0);
      check_eq("wrap_romaddr", bus.rom_address, 0);
      exp_q.push_back(32'h100);
      cyc(1, 0, 0);

      cyc(1, 1, 32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFF8);
      cyc(1, 0, 0);
      exp_q.push_back(32'hFFFF_FFFC);
      cyc(1, 0, 0);
      check_eq("wrap_pc4", bus.out_pc_plus4, 32'h0);
      exp_q.push_back(32'h0);
      cyc(1, 0, 0);

      cyc(1, 1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int k = 0; k < 2; k++) begin
         cyc(1, 0, 0);
         check_eq("fault_set", bus.fetch_fault, 1);
         check_eq("fault_valid", bus.out_valid, 0);
      end
      cyc(1, 1, 32'h80);
      exp_q.push_back(32'h80);
      cyc(1, 0, 0);
      check_eq("fault_clr", bus.fetch_fault, 0);
`else
      exp_q.push_back(32'h40);
      cyc(1, 0, 0);
      check_eq("nofault", bus.fetch_fault, 0);
`endif

      cyc(1, 1, 32'h20);
      cyc(0, 0, 0);
      check_eq("mid_pc", bus.out_pc, 32'h20);
      check_eq("mid_valid", bus.out_valid, 1);
      @(negedge clock);
      bus.out_ready = 1'b1;
      reset = 1'b1;
      #1;
      check_eq("arst_valid", bus.out_valid, 0);
      check_eq("arst_pc", bus.out_pc, 0);
      check_eq("arst_romaddr", bus.rom_address, 0);
      check_eq("arst_count", bus.fetch_count, 0);
      check_eq("arst_fault", bus.fetch_fault, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_eq("boot_valid2", bus.out_valid, 0);

      for (int i = 0; i < 65536; i++) begin
         exp_q.push_back(32'(i * 4));
         cyc(1, 0, 0);
         if (i == 65535) check_eq("count_max", bus.fetch_count, 32'hFFFF);
      end
      cyc(0, 0, 0);
      check_eq("count_wrap", bus.fetch_count, 0);
      check_eq("sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
